// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// Holds the receive FSM state encoding and the bit-order selector values.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam bit LSB_ORDER = 1'b0;
    localparam bit MSB_ORDER = 1'b1;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_if.sv
// Serial input side and parallel valid/ready output side of the receiver.
// The receiver takes the slave view; the stream source/consumer takes the master view.
interface sipo_if #(
    parameter int WIDTH = 4
);
    import sipo_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    logic             serial;
    logic             serial_valid;
    logic             align;
    logic [WIDTH-1:0] parallel_out;
    logic             parallel_valid;
    logic             parallel_ready;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    modport slave (
        input  serial,
        input  serial_valid,
        input  align,
        input  parallel_ready,
        output parallel_out,
        output parallel_valid,
        output overrun,
        output bit_cnt
    );

    modport master (
        output serial,
        output serial_valid,
        output align,
        output parallel_ready,
        input  parallel_out,
        input  parallel_valid,
        input  overrun,
        input  bit_cnt
    );

endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter: align restarts the frame, serial_valid advances it,
// tc flags the bit that completes a word (suppressed when align is present).
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = en && !clear && (cnt == LAST);

    // A bit arriving with align is the first bit of the new frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= en ? CW'(1) : '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Reassembles the 1-bit piso stream into WIDTH-bit words and offers each word
// on a valid/ready handshake one cycle after its last bit, with sticky overrun.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = MSB_ORDER
) (
    input  logic  clk,
    input  logic  rst,
    sipo_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    rx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_base;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             done_q;
    logic [WIDTH-1:0] pout;
    logic             pvalid;
    logic             ovr;

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.align),
        .en    (bus.serial_valid),
        .cnt   (cnt),
        .tc    (tc)
    );

    // A new frame starts from a clean register so no stale bits leak into it.
    always_comb begin
        shreg_base = (bus.align || state == IDLE) ? '0 : shreg;
        shreg_next = shreg_base;
        if (MSB_FIRST == MSB_ORDER) begin
            shreg_next = {shreg_base[WIDTH-2:0], bus.serial};
        end else begin
            shreg_next = {bus.serial, shreg_base[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= tc;
            if (bus.align) begin
                state <= bus.serial_valid ? SHIFT : IDLE;
                shreg <= bus.serial_valid ? shreg_next : '0;
            end else if (bus.serial_valid) begin
                state <= tc ? IDLE : SHIFT;
                shreg <= shreg_next;
            end
        end
    end

    // shreg still holds the finished word here even if the next frame's first bit lands now.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pout   <= '0;
            pvalid <= 1'b0;
            ovr    <= 1'b0;
        end else if (done_q) begin
            if (!pvalid || bus.parallel_ready) begin
                pout   <= shreg;
                pvalid <= 1'b1;
            end else begin
                ovr <= 1'b1;
            end
        end else if (pvalid && bus.parallel_ready) begin
            pvalid <= 1'b0;
        end
    end

    assign bus.parallel_out   = pout;
    assign bus.parallel_valid = pvalid;
    assign bus.overrun        = ovr;
    assign bus.bit_cnt        = cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed vector bench: one MSB-first and one LSB-first receiver share the same
// stimulus; each cycle's expected outputs are hand-computed in the table below.
module tb_sipo_deserializer;

    typedef struct {
        logic       rst;
        logic       ser;
        logic       sv;
        logic       al;
        logic       rdy;
        logic [3:0] e_msb;
        logic [3:0] e_lsb;
        logic       e_val;
        logic       e_ovr;
        logic [1:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial = 1'b0;
    logic serial_valid = 1'b0;
    logic align = 1'b0;
    logic parallel_ready = 1'b0;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    sipo_if #(.WIDTH(4)) m_if ();
    sipo_if #(.WIDTH(4)) l_if ();

    assign m_if.serial         = serial;
    assign m_if.serial_valid   = serial_valid;
    assign m_if.align          = align;
    assign m_if.parallel_ready = parallel_ready;
    assign l_if.serial         = serial;
    assign l_if.serial_valid   = serial_valid;
    assign l_if.align          = align;
    assign l_if.parallel_ready = parallel_ready;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input logic a, input logic rd);
        rst            = r;
        serial         = s;
        serial_valid   = v;
        align          = a;
        parallel_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic v, input logic a,
                          input logic rd, input logic [3:0] em, input logic [3:0] el,
                          input logic ev, input logic eo, input logic [1:0] ec);
        vec_t t;
        t.rst = r; t.ser = s; t.sv = v; t.al = a; t.rdy = rd;
        t.e_msb = em; t.e_lsb = el; t.e_val = ev; t.e_ovr = eo; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    initial begin
        //     rst ser sv al rdy  msb      lsb      val ovr cnt
        addVec(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
        // word 1,1,0,1 back to back with ready high
        addVec(1, 1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd1);
        addVec(1, 1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd2);
        addVec(1, 0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd3);
        addVec(1, 1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b1101, 4'b1011, 1, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd0);
        // bits 1,0, three idle cycles, then 1,1
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd1);
        addVec(1, 0, 1, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd2);
        addVec(1, 0, 0, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd2);
        addVec(1, 1, 0, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd2);
        addVec(1, 0, 0, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd2);
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd3);
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b1011, 4'b1101, 1, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b1011, 4'b1101, 0, 0, 2'd0);
        // 1000 held unconsumed, then 0011 completes on the cycle it is consumed
        addVec(1, 1, 1, 0, 0, 4'b1011, 4'b1101, 0, 0, 2'd1);
        addVec(1, 0, 1, 0, 0, 4'b1011, 4'b1101, 0, 0, 2'd2);
        addVec(1, 0, 1, 0, 0, 4'b1011, 4'b1101, 0, 0, 2'd3);
        addVec(1, 0, 1, 0, 0, 4'b1011, 4'b1101, 0, 0, 2'd0);
        addVec(1, 0, 1, 0, 0, 4'b1000, 4'b0001, 1, 0, 2'd1);
        addVec(1, 0, 1, 0, 0, 4'b1000, 4'b0001, 1, 0, 2'd2);
        addVec(1, 1, 1, 0, 0, 4'b1000, 4'b0001, 1, 0, 2'd3);
        addVec(1, 1, 1, 0, 0, 4'b1000, 4'b0001, 1, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b0011, 4'b1100, 1, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b0011, 4'b1100, 0, 0, 2'd0);
        // overrun: 1101 then 0110 with ready low
        addVec(1, 1, 1, 0, 0, 4'b0011, 4'b1100, 0, 0, 2'd1);
        addVec(1, 1, 1, 0, 0, 4'b0011, 4'b1100, 0, 0, 2'd2);
        addVec(1, 0, 1, 0, 0, 4'b0011, 4'b1100, 0, 0, 2'd3);
        addVec(1, 1, 1, 0, 0, 4'b0011, 4'b1100, 0, 0, 2'd0);
        addVec(1, 0, 1, 0, 0, 4'b1101, 4'b1011, 1, 0, 2'd1);
        addVec(1, 1, 1, 0, 0, 4'b1101, 4'b1011, 1, 0, 2'd2);
        addVec(1, 1, 1, 0, 0, 4'b1101, 4'b1011, 1, 0, 2'd3);
        addVec(1, 0, 1, 0, 0, 4'b1101, 4'b1011, 1, 0, 2'd0);
        addVec(1, 0, 0, 0, 0, 4'b1101, 4'b1011, 1, 1, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b1101, 4'b1011, 0, 1, 2'd0);
        // 1,0,1 aborted by align+bit 0 at the would-be completion, then 1,1,1
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 1, 2'd1);
        addVec(1, 0, 1, 0, 1, 4'b1101, 4'b1011, 0, 1, 2'd2);
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 1, 2'd3);
        addVec(1, 0, 1, 1, 1, 4'b1101, 4'b1011, 0, 1, 2'd1);
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 1, 2'd2);
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 1, 2'd3);
        addVec(1, 1, 1, 0, 1, 4'b1101, 4'b1011, 0, 1, 2'd0);
        addVec(1, 0, 0, 0, 0, 4'b0111, 4'b1110, 1, 1, 2'd0);
        // reset mid-word with a word pending, then 1010
        addVec(1, 1, 1, 0, 0, 4'b0111, 4'b1110, 1, 1, 2'd1);
        addVec(1, 0, 1, 0, 0, 4'b0111, 4'b1110, 1, 1, 2'd2);
        addVec(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
        addVec(1, 1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd1);
        addVec(1, 0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd2);
        addVec(1, 1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd3);
        addVec(1, 0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b1010, 4'b0101, 1, 0, 2'd0);
        addVec(1, 0, 0, 0, 1, 4'b1010, 4'b0101, 0, 0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ser, vecs[i].sv, vecs[i].al, vecs[i].rdy);
            checkOutput($sformatf("v%0d out_msb", i), 32'(m_if.parallel_out), 32'(vecs[i].e_msb));
            checkOutput($sformatf("v%0d out_lsb", i), 32'(l_if.parallel_out), 32'(vecs[i].e_lsb));
            checkOutput($sformatf("v%0d valid", i), 32'(m_if.parallel_valid), 32'(vecs[i].e_val));
            checkOutput($sformatf("v%0d overrun", i), 32'(m_if.overrun), 32'(vecs[i].e_ovr));
            checkOutput($sformatf("v%0d bit_cnt", i), 32'(m_if.bit_cnt), 32'(vecs[i].e_cnt));
            checkOutput($sformatf("v%0d bit_cnt_lsb", i), 32'(l_if.bit_cnt), 32'(vecs[i].e_cnt));
        end

        // align without a bit drops the partial word; then 0,0,1,1 and wait for it
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("hs cnt after bit", 32'(m_if.bit_cnt), 32'd1);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("hs cnt after align", 32'(m_if.bit_cnt), 32'd0);
        applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(1, 1, 1, 0, 1);
        applyStimulus(1, 1, 1, 0, 1);
        checkOutput("hs valid early", 32'(m_if.parallel_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (m_if.parallel_valid) break;
            applyStimulus(1, 0, 0, 0, 1);
        end
        checkOutput("hs valid", 32'(m_if.parallel_valid), 32'd1);
        checkOutput("hs out_msb", 32'(m_if.parallel_out), 32'h3);
        checkOutput("hs out_lsb", 32'(l_if.parallel_out), 32'hc);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("hs valid drop", 32'(m_if.parallel_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out receiver that reassembles the 1-bit stream produced by the team's piso serializer into WIDTH-bit words. It samples one bit per cycle while serial_valid is high and counts bits into a frame. Each completed word is presented on a valid/ready output handshake, with overrun detection. It sits at the receive end of the serial link, feeding the downstream parallel consumer.

Parameters:
WIDTH, 4, bits per word (>=2); must match the paired piso width
MSB_FIRST, 1, 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first bit lands in parallel_out[0]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on next rising clk edge)
serial  input  1  serial data bit
serial_valid  input  1  serial is a valid bit this cycle
align  input  1  frame-boundary strobe; restarts the bit count
parallel_out  output  WIDTH  last completed word
parallel_valid  output  1  parallel_out holds an unconsumed word
parallel_ready  input  1  consumer accepts the word when parallel_valid=1
overrun  output  1  sticky: a completed word was dropped
bit_cnt  output  $clog2(WIDTH)  bits collected in the current partial word (debug/status)

Behaviour:
- Reset (rst=0 at a clk edge): shift register=0, bit_cnt=0, parallel_out=0, parallel_valid=0, overrun=0, FSM=IDLE. Reset applies mid-word and discards any partial word or pending output.
- Receive FSM states:
  - IDLE: bit_cnt=0.
  - SHIFT: partial word present, 1..WIDTH-1 bits held.
- Transitions:
  - IDLE->SHIFT on serial_valid=1.
  - SHIFT stays in SHIFT while bit_cnt<WIDTH-1.
  - SHIFT->IDLE when serial_valid=1 and bit_cnt==WIDTH-1 (word complete).
  - If WIDTH bits arrive back-to-back, the FSM returns to IDLE and immediately re-enters SHIFT on the next valid bit, with no gap cycles required.
- Shifting:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], serial}.
  - MSB_FIRST=0: shreg <= {serial, shreg[WIDTH-1:1]}.
  - A cycle with serial_valid=0 holds all receive state; gaps between bits are allowed.
- Word completion: the cycle that samples the WIDTH-th bit is the completion cycle. parallel_out and parallel_valid update at the following edge, i.e. 1-cycle latency from the last bit's sampling edge. The completed word includes that last bit.
- Output handshake:
  - Word consumed at an edge where parallel_valid=1 and parallel_ready=1; parallel_valid then drops unless a new word completes in the same cycle.
  - parallel_out is stable while parallel_valid=1 and no new word is loaded.
- Simultaneous completion and consume (valid=1, ready=1, completion): new word loaded, parallel_valid stays 1, overrun unchanged.
- Overrun (completion while valid=1 and ready=0): new word dropped, parallel_out keeps the old word, overrun<=1. overrun stays set until reset.
- align=1:
  - bit_cnt cleared and the partial word discarded.
  - If serial_valid=1 in the same cycle, that bit becomes bit 1 of the new word (bit_cnt->1, FSM=SHIFT); otherwise FSM=IDLE.
  - align never affects parallel_out, parallel_valid or overrun.
  - align has priority over completion: with bit_cnt==WIDTH-1 and align=1, no word is emitted.
- Width rules: bit_cnt wraps WIDTH-1 -> 0 on completion. No other arithmetic.

Decomposition:
- Shared package sipo_pkg: FSM state typedef (IDLE, SHIFT) and the MSB_FIRST encoding constants.
- One natural sub-module: sipo_bit_counter, the modulo-WIDTH counter with clear (align) and enable (serial_valid) that produces a terminal-count flag. Everything else stays in sipo_deserializer.

Test Plan:
- WIDTH=4, MSB_FIRST=1, after reset send 1,1,0,1 on consecutive cycles with ready=1 -> parallel_out=4'b1101, parallel_valid high exactly 1 cycle, starting 1 cycle after the 4th bit edge.
- MSB_FIRST=0, same bits -> parallel_out=4'b1011.
- Bits 1,0 then 3 idle cycles then 1,1 -> output 4'b1011; bit_cnt holds 2 during the gap.
- ready=0, send two words 1101 then 0110 -> parallel_out stays 1101, overrun=1. Then ready=1 -> valid drops after one edge.
- Send 1,0,1, then align together with serial_valid=1 and serial=0, then 1,1,1 -> no word from the aborted frame; next word 4'b0111.
- Assert rst=0 after 2 bits of a word and while a word is pending -> all outputs 0 next edge. A fresh 4 bits 1010 then yields 4'b1010.
